// File: rtl/writeback_stage.sv
// Write-back stage: captures the MEM/WB register on each step pulse, drives a
// one-cycle register-file write, bypasses it onto decode reads, and keeps debug state.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [REG_AW-1:0] mem_write_reg,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  output logic [DATA_W-1:0] dataRs,
  output logic [DATA_W-1:0] dataRt,
  output logic [CNT_W-1:0]  retired_count,
  output logic [DATA_W-1:0] last_write_data
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wb_state_e;

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  wb_state_e           state_q, state_d;
  logic                wb_reg_write_q, wb_reg_write_d;
  logic [REG_AW-1:0]   wb_write_reg_q, wb_write_reg_d;
  logic [DATA_W-1:0]   wb_write_data_q, wb_write_data_d;
  logic [CNT_W-1:0]    retired_count_q, retired_count_d;
  logic [DATA_W-1:0]   last_write_data_q, last_write_data_d;
  logic [DATA_W-1:0]   data_rs_s, data_rt_s;

  // Next-state: a step loads a new slot; without a step the write pulse ends
  // but index/data are held. Commits come from the slot that was just presented.
  always_comb begin
    state_d           = state_q;
    wb_reg_write_d    = wb_reg_write_q;
    wb_write_reg_d    = wb_write_reg_q;
    wb_write_data_d   = wb_write_data_q;
    retired_count_d   = retired_count_q;
    last_write_data_d = last_write_data_q;

    if (step) begin
      wb_write_reg_d  = mem_write_reg;
      wb_write_data_d = mem_to_reg ? mem_read_data : mem_alu_result;
      state_d         = mem_valid ? S_WRITE : S_IDLE;
      wb_reg_write_d  = mem_valid & mem_reg_write & (mem_write_reg != REG_ZERO);
    end else begin
      state_d        = S_IDLE;
      wb_reg_write_d = 1'b0;
    end

    case (state_q)
      S_WRITE: begin
        retired_count_d = retired_count_q + CNT_ONE;
        if (wb_reg_write_q) begin
          last_write_data_d = wb_write_data_q;
        end else begin
          last_write_data_d = last_write_data_q;
        end
      end
      S_IDLE: begin
        retired_count_d = retired_count_q;
      end
      default: begin
        retired_count_d = retired_count_q;
      end
    endcase
  end

  // State registers; reset aborts any in-flight write before it can commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= S_IDLE;
      wb_reg_write_q    <= 1'b0;
      wb_write_reg_q    <= REG_ZERO;
      wb_write_data_q   <= {DATA_W{1'b0}};
      retired_count_q   <= {CNT_W{1'b0}};
      last_write_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q           <= state_d;
      wb_reg_write_q    <= wb_reg_write_d;
      wb_write_reg_q    <= wb_write_reg_d;
      wb_write_data_q   <= wb_write_data_d;
      retired_count_q   <= retired_count_d;
      last_write_data_q <= last_write_data_d;
    end
  end

  // Same-cycle bypass of the pending write onto decode reads; r0 is never bypassed.
  always_comb begin
    data_rs_s = rf_rs_data;
    data_rt_s = rf_rt_data;
    if (wb_reg_write_q && (id_rs == wb_write_reg_q) && (id_rs != REG_ZERO)) begin
      data_rs_s = wb_write_data_q;
    end else begin
      data_rs_s = rf_rs_data;
    end
    if (wb_reg_write_q && (id_rt == wb_write_reg_q) && (id_rt != REG_ZERO)) begin
      data_rt_s = wb_write_data_q;
    end else begin
      data_rt_s = rf_rt_data;
    end
  end

  assign wb_reg_write    = wb_reg_write_q;
  assign wb_write_reg    = wb_write_reg_q;
  assign wb_write_data   = wb_write_data_q;
  assign retired_count   = retired_count_q;
  assign last_write_data = last_write_data_q;
  assign dataRs          = data_rs_s;
  assign dataRt          = data_rt_s;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        step, mem_valid, mem_reg_write, mem_to_reg;
  logic [31:0] mem_alu_result, mem_read_data;
  logic [4:0]  mem_write_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic [4:0]  id_rs, id_rt;
  logic [31:0] rf_rs_data, rf_rt_data, dataRs, dataRt;
  logic [15:0] retired_count;
  logic [31:0] last_write_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  writeback_stage dut (
    .clk(clk), .reset(reset), .step(step), .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write), .mem_to_reg(mem_to_reg),
    .mem_alu_result(mem_alu_result), .mem_read_data(mem_read_data),
    .mem_write_reg(mem_write_reg), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .id_rs(id_rs), .id_rt(id_rt), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .dataRs(dataRs), .dataRt(dataRt), .retired_count(retired_count),
    .last_write_data(last_write_data)
  );

  always #5 clk = ~clk;

  task automatic set_instr(input logic s, input logic v, input logic rw, input logic m2r,
                           input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] r);
    step = s; mem_valid = v; mem_reg_write = rw; mem_to_reg = m2r;
    mem_alu_result = alu; mem_read_data = rd; mem_write_reg = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    id_rs = 5'd0; id_rt = 5'd0; rf_rs_data = 32'h0; rf_rt_data = 32'h0;
    do_reset();
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL reset_we got %0h exp 0", wb_reg_write); else pass_cnt++;
    total_cnt++; if (wb_write_reg !== 5'd0) $display("FAIL reset_reg got %0h exp 0", wb_write_reg); else pass_cnt++;
    total_cnt++; if (wb_write_data !== 32'h0) $display("FAIL reset_data got %0h exp 0", wb_write_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 16'h0) $display("FAIL reset_cnt got %0h exp 0", retired_count); else pass_cnt++;
    total_cnt++; if (last_write_data !== 32'h0) $display("FAIL reset_last got %0h exp 0", last_write_data); else pass_cnt++;
  endtask

  task automatic test_alu_write();
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_0000, 5'd5);
    tick();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    total_cnt++; if (wb_reg_write !== 1'b1) $display("FAIL alu_we got %0h exp 1", wb_reg_write); else pass_cnt++;
    total_cnt++; if (wb_write_reg !== 5'd5) $display("FAIL alu_reg got %0h exp 5", wb_write_reg); else pass_cnt++;
    total_cnt++; if (wb_write_data !== 32'h1234) $display("FAIL alu_data got %0h exp 1234", wb_write_data); else pass_cnt++;
    total_cnt++; if (retired_count !== 16'd0) $display("FAIL alu_cnt_early got %0h exp 0", retired_count); else pass_cnt++;
    tick();
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL alu_we_off got %0h exp 0", wb_reg_write); else pass_cnt++;
    total_cnt++; if (retired_count !== 16'd1) $display("FAIL alu_cnt got %0h exp 1", retired_count); else pass_cnt++;
    total_cnt++; if (last_write_data !== 32'h1234) $display("FAIL alu_last got %0h exp 1234", last_write_data); else pass_cnt++;
    total_cnt++; if (wb_write_data !== 32'h1234) $display("FAIL alu_hold got %0h exp 1234", wb_write_data); else pass_cnt++;
  endtask

  task automatic test_load_bypass();
    id_rt = 5'd9; rf_rt_data = 32'h0;
    set_instr(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd9);
    tick();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    total_cnt++; if (wb_write_data !== 32'hDEAD_BEEF) $display("FAIL load_data got %0h exp deadbeef", wb_write_data); else pass_cnt++;
    total_cnt++; if (dataRt !== 32'hDEAD_BEEF) $display("FAIL load_byp_rt got %0h exp deadbeef", dataRt); else pass_cnt++;
    tick();
    total_cnt++; if (dataRt !== 32'h0) $display("FAIL load_byp_off got %0h exp 0", dataRt); else pass_cnt++;
    total_cnt++; if (retired_count !== 16'd2) $display("FAIL load_cnt got %0h exp 2", retired_count); else pass_cnt++;
    total_cnt++; if (last_write_data !== 32'hDEAD_BEEF) $display("FAIL load_last got %0h exp deadbeef", last_write_data); else pass_cnt++;
    id_rt = 5'd0;
  endtask

  task automatic test_r0_write();
    id_rs = 5'd0; rf_rs_data = 32'hAAAA_0000;
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd0);
    tick();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL r0_we got %0h exp 0", wb_reg_write); else pass_cnt++;
    total_cnt++; if (dataRs !== 32'hAAAA_0000) $display("FAIL r0_byp got %0h exp aaaa0000", dataRs); else pass_cnt++;
    tick();
    total_cnt++; if (retired_count !== 16'd3) $display("FAIL r0_cnt got %0h exp 3", retired_count); else pass_cnt++;
    total_cnt++; if (last_write_data !== 32'hDEAD_BEEF) $display("FAIL r0_last got %0h exp deadbeef", last_write_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0077, 32'h0, 5'd7);
    tick();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL bubble_we got %0h exp 0", wb_reg_write); else pass_cnt++;
    tick();
    total_cnt++; if (retired_count !== 16'd0) $display("FAIL bubble_cnt got %0h exp 0", retired_count); else pass_cnt++;
    id_rs = 5'd2; rf_rs_data = 32'h0000_BBBB;
    for (int i = 1; i <= 3; i++) begin
      set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'(i), 32'h0, 5'(i));
      tick();
      total_cnt++; if (wb_reg_write !== 1'b1) $display("FAIL b2b_we%0d got %0h exp 1", i, wb_reg_write); else pass_cnt++;
      total_cnt++; if (wb_write_data !== 32'(i)) $display("FAIL b2b_data%0d got %0h exp %0h", i, wb_write_data, i); else pass_cnt++;
      total_cnt++; if (retired_count !== 16'(i - 1)) $display("FAIL b2b_cnt%0d got %0h exp %0h", i, retired_count, i - 1); else pass_cnt++;
    end
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL b2b_idle_we got %0h exp 0", wb_reg_write); else pass_cnt++;
    total_cnt++; if (retired_count !== 16'd3) $display("FAIL b2b_cnt_end got %0h exp 3", retired_count); else pass_cnt++;
    total_cnt++; if (last_write_data !== 32'd3) $display("FAIL b2b_last got %0h exp 3", last_write_data); else pass_cnt++;
    total_cnt++; if (dataRs !== 32'h0000_BBBB) $display("FAIL b2b_byp_off got %0h exp bbbb", dataRs); else pass_cnt++;
    tick();
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL b2b_idle2_we got %0h exp 0", wb_reg_write); else pass_cnt++;
    total_cnt++; if (retired_count !== 16'd3) $display("FAIL b2b_cnt_hold got %0h exp 3", retired_count); else pass_cnt++;
    id_rs = 5'd0;
  endtask

  task automatic test_wrap();
    do_reset();
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd1);
    repeat (65535) tick();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    total_cnt++; if (retired_count !== 16'hFFFF) $display("FAIL wrap_pre got %0h exp ffff", retired_count); else pass_cnt++;
    set_instr(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd1);
    tick();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    tick();
    total_cnt++; if (retired_count !== 16'h0) $display("FAIL wrap_cnt got %0h exp 0", retired_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_write();
    id_rs = 5'd4; rf_rs_data = 32'h0000_CCCC;
    set_instr(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd4);
    tick();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    total_cnt++; if (wb_reg_write !== 1'b1) $display("FAIL rst_mid_pre got %0h exp 1", wb_reg_write); else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL rst_mid_we got %0h exp 0", wb_reg_write); else pass_cnt++;
    total_cnt++; if (wb_write_data !== 32'h0) $display("FAIL rst_mid_data got %0h exp 0", wb_write_data); else pass_cnt++;
    total_cnt++; if (wb_write_reg !== 5'd0) $display("FAIL rst_mid_reg got %0h exp 0", wb_write_reg); else pass_cnt++;
    total_cnt++; if (dataRs !== 32'h0000_CCCC) $display("FAIL rst_mid_byp got %0h exp cccc", dataRs); else pass_cnt++;
    tick();
    @(negedge clk); reset = 1'b0;
    tick();
    total_cnt++; if (retired_count !== 16'd0) $display("FAIL rst_mid_cnt got %0h exp 0", retired_count); else pass_cnt++;
    total_cnt++; if (last_write_data !== 32'h0) $display("FAIL rst_mid_last got %0h exp 0", last_write_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_bypass();
    test_r0_write();
    test_back_to_back();
    test_wrap();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
